// File: rtl/div_pkg.sv
// Purpose: shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

   // Controller states, encoded in two bits.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Default operand width and the quotient reported on a zero divisor
   // (all ones of the operand width).
   localparam int                   DEF_WIDTH    = 4;
   localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

   // Iteration counter width: must hold values 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/full_adder_1_bit.sv
// Purpose: single-bit full adder cell used to build ripple datapaths.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, cin -> sum, cout.
module full_adder_1_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtractor_n_bit.sv
// Purpose: N-bit ripple subtractor, diff = a - b as a + ~b + 1.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (N bits) -> diff (N bits), no_borrow (final carry-out, 1 when a >= b).
module subtractor_n_bit #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         no_borrow
);

   logic [N:0] c;

   // Carry-in of 1 supplies the +1 of the two's complement of b.
   assign c[0] = 1'b1;

   for (genvar i = 0; i < N; i++) begin : g_cell
      full_adder_1_bit u_fa (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (c[i]),
         .sum  (diff[i]),
         .cout (c[i+1])
      );
   end

   assign no_borrow = c[N];

endmodule

// File: rtl/divider_4_bit_seq.sv
// Purpose: sequential restoring divider, one quotient bit per clock.
// Latency: WIDTH cycles in RUN then a one-cycle done; divide-by-zero reports done one cycle after accept.
// Backpressure: none; start is only honoured in IDLE, requests in RUN/DONE are dropped.
// Ports: clk, reset (sync, active-high), start, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out (results held until the next accept).
module divider_4_bit_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   r;        // partial remainder, one guard bit wide
   logic [WIDTH-1:0] q;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH:0]   r_iter;
   logic [WIDTH-1:0] q_iter;
   logic             last_iter;

   // Bring the next dividend bit into the partial remainder. The guard bit
   // of r is always 0 here because r < divisor after every iteration.
   assign r_shift = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};

   subtractor_n_bit #(
      .N (WIDTH + 1)
   ) u_sub (
      .a         (r_shift),
      .b         ({1'b0, dvsr}),
      .diff      (trial),
      .no_borrow (no_borrow)
   );

   // Restore on borrow: keep the shifted value and record a 0 quotient bit.
   assign r_iter    = no_borrow ? trial : r_shift;
   assign q_iter    = {q[WIDTH-2:0], no_borrow};
   assign last_iter = (count == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         r           <= '0;
         q           <= '0;
         dvsr        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor != '0) begin
                     dvsr  <= divisor;
                     q     <= dividend;
                     r     <= '0;
                     count <= '0;
                  end else begin
                     // Zero divisor skips RUN and reports immediately.
                     quotient    <= {WIDTH{1'b1}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               r     <= r_iter;
               q     <= q_iter;
               count <= count + CW'(1);
               if (last_iter) begin
                  quotient    <= q_iter;
                  remainder   <= r_iter[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_4_bit_seq.sv
module tb_divider_4_bit_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   divider_4_bit_seq #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Issue one request from IDLE and wait (bounded) for done.
   // Returns the cycle of done counted from the capture edge and the busy cycles seen.
   task automatic run(input logic [3:0] a, input logic [3:0] b,
                      output int lat, output int bcnt);
      @(negedge clk);
      chk("idle_done_low", {31'd0, done}, 32'd0);
      chk("idle_busy_low", {31'd0, busy}, 32'd0);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 4'($urandom);
      divisor  = 4'($urandom);
      lat  = 1;
      bcnt = 0;
      while (lat < 20 && done !== 1'b1) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                         input int eq, input int er, input int edbz);
      int lat, bcnt;
      run(a, b, lat, bcnt);
      chk("quotient", {28'd0, quotient}, eq);
      chk("remainder", {28'd0, remainder}, er);
      chk("div_by_zero", {31'd0, div_by_zero}, edbz);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("latency", lat, (b == 4'd0) ? 1 : 5);
      chk("busy_cycles", bcnt, (b == 4'd0) ? 0 : 4);
   endtask

   initial begin
      int n_done;
      reset    = 1'b1;
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", {28'd0, quotient}, 32'd0);
      chk("rst_r", {28'd0, remainder}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;

      // Basic and back-to-back requests.
      do_div(4'd13, 4'd3, 4, 1, 0);
      do_div(4'd15, 4'd1, 15, 0, 0);
      do_div(4'd3, 4'd9, 0, 3, 0);

      // Divide by zero, then a normal request clears the flag.
      do_div(4'd7, 4'd0, 15, 7, 1);
      do_div(4'd0, 4'd5, 0, 0, 0);

      // A start raised during RUN is dropped.
      @(negedge clk);
      dividend = 4'd12; divisor = 4'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      dividend = 4'd9; divisor = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) begin
            n_done++;
            chk("ign_q", {28'd0, quotient}, 32'd2);
            chk("ign_r", {28'd0, remainder}, 32'd2);
         end
         @(negedge clk);
      end
      chk("ign_done_count", n_done, 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk("hold_q", {28'd0, quotient}, 32'd2);
         chk("hold_r", {28'd0, remainder}, 32'd2);
         chk("hold_busy", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end

      // Reset in the middle of RUN.
      dividend = 4'd14; divisor = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_q", {28'd0, quotient}, 32'd0);
      chk("mid_rst_r", {28'd0, remainder}, 32'd0);
      chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      chk("mid_rst_no_done", n_done, 32'd0);
      do_div(4'd14, 4'd3, 4, 2, 0);

      // Reset together with start: reset wins.
      @(negedge clk);
      dividend = 4'd5; divisor = 4'd1; start = 1'b1; reset = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);
      chk("rst_start_q", {28'd0, quotient}, 32'd0);

      // Exhaustive sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) do_div(4'(a), 4'(b), 15, a, 1);
            else        do_div(4'(a), 4'(b), a / b, a % b, 0);
         end
      end

      @(negedge clk);
      chk("final_done_low", {31'd0, done}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
